pipe_stage_skid: RTL and testbench

Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It carries one opaque DATA_W payload plus a per-entry redirect flag between two valid/ready stages. An optional two-entry skid mode gives full throughput with a registered in_ready. It adds an explicit flush, redirect-kill of younger entries, occupancy reporting and a saturating kill counter.

---
 rtl/pipe_stage_skid.sv | 125 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage carrying a payload plus redirect flag, with optional
// two-entry skid buffer, flush, redirect-kill of younger entries and a kill counter.
module pipe_stage_skid #(
    parameter int DATA_W         = 32,
    parameter int SKID           = 1,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_redirect,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_redirect,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  kill_cnt
);

    // Bit 0 = main entry valid, bit 1 = skid entry valid, so both are direct flops.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_TWO   = 2'b11
    } state_t;

    state_t state_q, state_d;

    logic              main_valid, skid_valid;
    logic              accept, fire, redir_kill;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              main_redir, skid_redir;
    logic [1:0]        n_kill;
    logic [CNT_W+1:0]  kill_sum;

    assign accept     = in_valid && in_ready;
    assign fire       = main_valid && out_ready;
    assign redir_kill = fire && main_redir;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush_i || redir_kill) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: if (accept) state_d = S_ONE;
                S_ONE: begin
                    if (fire && !accept)      state_d = S_EMPTY;
                    else if (accept && !fire) state_d = (SKID != 0) ? S_TWO : S_ONE;
                end
                S_TWO:   if (fire) state_d = S_ONE;
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        main_valid = state_q[0];
        skid_valid = state_q[1];
        out_valid  = main_valid;
        occupancy  = {skid_valid, main_valid & ~skid_valid};
        // Skid mode: in_ready comes straight off the skid-valid flop, never from out_ready.
        if (SKID != 0) in_ready = !skid_valid;
        else           in_ready = !main_valid || out_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_data  <= '0;
            main_redir <= 1'b0;
            skid_data  <= '0;
            skid_redir <= 1'b0;
        end else if (flush_i || redir_kill) begin
            if (CLEAR_ON_FLUSH != 0) begin
                main_data  <= '0;
                main_redir <= 1'b0;
                skid_data  <= '0;
                skid_redir <= 1'b0;
            end
        end else begin
            if (skid_valid && fire) begin
                main_data  <= skid_data;
                main_redir <= skid_redir;
            end else if (accept && (!main_valid || fire)) begin
                main_data  <= in_data;
                main_redir <= in_redirect;
            end
            if ((SKID != 0) && accept && main_valid && !fire) begin
                skid_data  <= in_data;
                skid_redir <= in_redirect;
            end
        end
    end

    // Flush discards everything held plus the same-cycle accept; a redirect-kill
    // spares the retiring head. Flush takes precedence so nothing is counted twice.
    always_comb begin
        n_kill = 2'd0;
        if (flush_i)
            n_kill = {1'b0, main_valid} + {1'b0, skid_valid} + {1'b0, accept};
        else if (redir_kill)
            n_kill = {1'b0, skid_valid} + {1'b0, accept};
    end

    assign kill_sum = {2'b00, kill_cnt} + {{CNT_W{1'b0}}, n_kill};

    always_ff @(posedge clk) begin
        if (reset)                             kill_cnt <= '0;
        else if (kill_sum[CNT_W+1:CNT_W] != 0) kill_cnt <= '1;
        else                                   kill_cnt <= kill_sum[CNT_W-1:0];
    end

    assign out_data     = main_data;
    assign out_redirect = main_redir;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: queue scoreboard on the skid instance, directed checks
// on single-entry and narrow-counter instances.
module tb_pipe_stage_skid;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // skid instance
    logic        m_flush = 0, m_in_valid = 0, m_in_redir = 0, m_out_ready = 0;
    logic [31:0] m_in_data = 0;
    logic        m_in_ready, m_out_valid, m_out_redir;
    logic [31:0] m_out_data;
    logic [1:0]  m_occ;
    logic [7:0]  m_kill;

    pipe_stage_skid #(.DATA_W(32), .SKID(1), .CLEAR_ON_FLUSH(1), .CNT_W(8)) u_skid (
        .clk(clk), .reset(reset), .flush_i(m_flush),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data), .in_redirect(m_in_redir),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data),
        .out_redirect(m_out_redir), .occupancy(m_occ), .kill_cnt(m_kill));

    // single-entry instance
    logic        s_flush = 0, s_in_valid = 0, s_in_redir = 0, s_out_ready = 0;
    logic [31:0] s_in_data = 0;
    logic        s_in_ready, s_out_valid, s_out_redir;
    logic [31:0] s_out_data;
    logic [1:0]  s_occ;
    logic [7:0]  s_kill;

    pipe_stage_skid #(.DATA_W(32), .SKID(0), .CLEAR_ON_FLUSH(1), .CNT_W(8)) u_single (
        .clk(clk), .reset(reset), .flush_i(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_redirect(s_in_redir),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_redirect(s_out_redir), .occupancy(s_occ), .kill_cnt(s_kill));

    // narrow counter instance
    logic       t_flush = 0, t_in_valid = 0, t_in_redir = 0, t_out_ready = 0;
    logic [7:0] t_in_data = 0;
    logic       t_in_ready, t_out_valid, t_out_redir;
    logic [7:0] t_out_data;
    logic [1:0] t_occ;
    logic [1:0] t_kill;

    pipe_stage_skid #(.DATA_W(8), .SKID(1), .CLEAR_ON_FLUSH(1), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .flush_i(t_flush),
        .in_valid(t_in_valid), .in_ready(t_in_ready), .in_data(t_in_data), .in_redirect(t_in_redir),
        .out_valid(t_out_valid), .out_ready(t_out_ready), .out_data(t_out_data),
        .out_redirect(t_out_redir), .occupancy(t_occ), .kill_cnt(t_kill));

    // Scoreboard for u_skid: entries pushed on accept, popped and compared on fire.
    logic [32:0] sb_q[$];
    int          exp_kill = 0;
    logic        sb_acc, sb_fire, sb_hd_redir;
    int          sb_sz0;
    logic [32:0] sb_hd;

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            exp_kill = 0;
        end else begin
            chk("sb_occupancy", m_occ, sb_q.size());
            chk("sb_out_valid", m_out_valid, sb_q.size() != 0);
            chk("sb_in_ready", m_in_ready, sb_q.size() < 2);
            chk("sb_kill_cnt", m_kill, exp_kill);
            sb_acc      = m_in_valid && m_in_ready;
            sb_fire     = m_out_valid && m_out_ready;
            sb_sz0      = sb_q.size();
            sb_hd_redir = 1'b0;
            if (sb_fire) begin
                chk("sb_fire_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    sb_hd = sb_q.pop_front();
                    chk("sb_out_data", m_out_data, sb_hd[31:0]);
                    chk("sb_out_redirect", m_out_redir, sb_hd[32]);
                    sb_hd_redir = sb_hd[32];
                end
            end
            if (m_flush) begin
                exp_kill = sat8(exp_kill + sb_sz0 + int'(sb_acc));
                sb_q.delete();
            end else if (sb_hd_redir) begin
                exp_kill = sat8(exp_kill + sb_q.size() + int'(sb_acc));
                sb_q.delete();
            end else if (sb_acc) begin
                sb_q.push_back({m_in_redir, m_in_data});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        tick(); tick();
        chk("rst_out_valid", m_out_valid, 0);
        chk("rst_out_data", m_out_data, 0);
        chk("rst_in_ready", m_in_ready, 1);
        chk("rst_kill", m_kill, 0);
        chk("rst_single_in_ready", s_in_ready, 1);
        reset = 1'b0;

        // streaming
        m_in_valid = 1; m_out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            m_in_data = 32'h10 + i;
            chk("stream_in_ready", m_in_ready, 1);
            tick();
            chk("stream_out_valid", m_out_valid, 1);
            chk("stream_out_data", m_out_data, 32'h10 + i);
            chk("stream_occ", m_occ, 1);
        end
        m_in_valid = 0;
        tick();
        chk("stream_drained", m_out_valid, 0);

        // backpressure
        m_out_ready = 0; m_in_valid = 1; m_in_data = 32'hA0;
        tick();
        m_in_data = 32'hA1;
        tick();
        m_in_valid = 0;
        chk("bp_occ", m_occ, 2);
        chk("bp_in_ready", m_in_ready, 0);
        chk("bp_head", m_out_data, 32'hA0);
        tick();
        chk("bp_hold", m_out_data, 32'hA0);
        m_out_ready = 1;
        tick();
        chk("bp_second", m_out_data, 32'hA1);
        chk("bp_in_ready_back", m_in_ready, 1);
        tick();
        chk("bp_drained", m_out_valid, 0);

        // redirect-kill with skid entry
        m_out_ready = 0; m_in_valid = 1; m_in_data = 32'hB0; m_in_redir = 1;
        tick();
        m_in_data = 32'hB1; m_in_redir = 0;
        tick();
        m_in_valid = 0; m_out_ready = 1;
        tick();
        chk("rk_out_valid", m_out_valid, 0);
        chk("rk_occ", m_occ, 0);
        chk("rk_kill", m_kill, 1);
        // redirect-kill with same-cycle accept
        m_out_ready = 0; m_in_valid = 1; m_in_data = 32'hB0; m_in_redir = 1;
        tick();
        m_in_data = 32'hB2; m_in_redir = 0; m_out_ready = 1;
        tick();
        m_in_valid = 0;
        chk("rk2_out_valid", m_out_valid, 0);
        chk("rk2_kill", m_kill, 2);

        // flush with two entries held (upstream offer not accepted: skid full)
        m_out_ready = 0; m_in_valid = 1; m_in_data = 32'hC0;
        tick();
        m_in_data = 32'hC1;
        tick();
        m_flush = 1; m_in_data = 32'hC2;
        tick();
        m_flush = 0; m_in_valid = 0;
        chk("fl_out_valid", m_out_valid, 0);
        chk("fl_occ", m_occ, 0);
        chk("fl_kill", m_kill, 4);
        chk("fl_out_data", m_out_data, 0);
        // flush with one held plus a same-cycle accept
        m_in_valid = 1; m_in_data = 32'hC3;
        tick();
        m_flush = 1; m_in_data = 32'hC4;
        tick();
        m_flush = 0; m_in_valid = 0;
        chk("fl2_kill", m_kill, 6);
        chk("fl2_out_data", m_out_data, 0);
        // flush coinciding with a redirect retirement
        m_in_valid = 1; m_in_data = 32'hD0; m_in_redir = 1;
        tick();
        m_in_data = 32'hD1; m_in_redir = 0;
        tick();
        m_in_valid = 0; m_flush = 1; m_out_ready = 1;
        tick();
        m_flush = 0;
        chk("fl3_kill", m_kill, 8);
        chk("fl3_occ", m_occ, 0);

        // random traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            m_in_valid  = ($urandom_range(0, 9) < 7);
            m_in_data   = $urandom;
            m_in_redir  = ($urandom_range(0, 7) == 0);
            m_out_ready = ($urandom_range(0, 9) < 6);
            m_flush     = ($urandom_range(0, 15) == 0);
            tick();
        end
        m_in_valid = 0; m_flush = 0; m_out_ready = 1; m_in_redir = 0;
        tick(); tick(); tick();

        // reset mid-transfer
        m_out_ready = 0; m_in_valid = 1; m_in_data = 32'hE0;
        tick();
        m_in_data = 32'hE1; m_in_redir = 1;
        tick();
        m_in_valid = 0; m_in_redir = 0;
        chk("mr_occ_before", m_occ, 2);
        reset = 1;
        tick();
        chk("mr_out_valid", m_out_valid, 0);
        chk("mr_out_data", m_out_data, 0);
        chk("mr_out_redirect", m_out_redir, 0);
        chk("mr_occ", m_occ, 0);
        chk("mr_kill", m_kill, 0);
        chk("mr_in_ready", m_in_ready, 1);
        reset = 0;
        tick();
        chk("mr_after", m_out_valid, 0);

        // single-entry mode
        s_out_ready = 0; s_in_valid = 1; s_in_data = 32'h55;
        tick();
        s_in_data = 32'h66;
        #1;
        chk("se_out_valid", s_out_valid, 1);
        chk("se_in_ready_blocked", s_in_ready, 0);
        chk("se_head", s_out_data, 32'h55);
        chk("se_occ", s_occ, 1);
        s_out_ready = 1;
        #1;
        chk("se_in_ready_comb", s_in_ready, 1);
        tick();
        chk("se_no_bubble_valid", s_out_valid, 1);
        chk("se_no_bubble_data", s_out_data, 32'h66);
        s_in_valid = 0;
        tick();
        chk("se_drained", s_out_valid, 0);
        s_out_ready = 0; s_in_valid = 1; s_in_data = 32'h70; s_in_redir = 1;
        tick();
        s_in_data = 32'h71; s_in_redir = 0; s_out_ready = 1;
        tick();
        s_in_valid = 0;
        chk("se_rk_valid", s_out_valid, 0);
        chk("se_rk_kill", s_kill, 1);

        // counter saturation
        t_out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            t_in_valid = 1; t_in_data = 8'(i + 1);
            tick();
            t_in_valid = 0; t_flush = 1;
            tick();
            t_flush = 0;
            chk("sat_kill", t_kill, (i < 3) ? i + 1 : 3);
            chk("sat_out_data", t_out_data, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
